scene_sequencer: RTL and testbench



---
 rtl/scene_sequencer.sv | 173 +++++++++++++++++
 tb/tb_scene_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate scene controller driven by VGA vertical sync.
// Derives one tick per frame from v_sync and walks each scene through
// fade-in, hold and fade-out, exporting scene index and 2-bit brightness.
// Optional feature macro: SCENE_SEQ_FADE_EN. When undefined, fade is fixed
// at full brightness and each scene is a single hold phase.
module scene_sequencer #(
  parameter int   NUM_SCENES  = 4,
  parameter int   HOLD_FRAMES = 120,
  parameter int   FADE_STEP   = 8,
  parameter logic VSYNC_POL   = 1'b0,
  localparam int  SW          = (NUM_SCENES > 2) ? $clog2(NUM_SCENES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v_sync,
  input  logic          pause,
  input  logic          skip,
  output logic [SW-1:0] scene,
  output logic [1:0]    fade,
  output logic [7:0]    frame_count,
  output logic          scene_start
);

  localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [SW-1:0] SCENE_LAST = SW'(NUM_SCENES - 1);

  // Reject parameter values the counters cannot represent.
  if (NUM_SCENES < 2 || HOLD_FRAMES < 1 || HOLD_FRAMES > 255 ||
      FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_param
    $error("scene_sequencer: parameter out of range");
  end

  logic          vs_prev;
  logic          tick;
  logic          step;
  logic          skip_pending;
  logic          skip_eff;
  logic [SW-1:0] scene_inc;
  logic [SW-1:0] scene_next;
  logic [7:0]    fc_next;
  logic          start_next;

  // A tick is the first cycle of the active sync level; a paused tick is dropped.
  assign tick      = (v_sync == VSYNC_POL) && (vs_prev != VSYNC_POL);
  assign step      = tick && !pause;
  assign skip_eff  = skip_pending || skip;
  assign scene_inc = (scene == SCENE_LAST) ? '0 : scene + 1'b1;

  // Previous v_sync resets to the active level so reset release cannot tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_prev <= VSYNC_POL;
    else     vs_prev <= v_sync;
  end

  // Skip request latch: held across paused ticks, consumed by an accepted tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       skip_pending <= 1'b0;
    else if (step) skip_pending <= 1'b0;
    else if (skip) skip_pending <= 1'b1;
  end

`ifdef SCENE_SEQ_FADE_EN
  localparam logic [1:0] ST_FADE_IN  = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_FADE_OUT = 2'd2;
  localparam logic [7:0] STEP_LAST   = 8'(FADE_STEP - 1);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] fade_next;

  // Phase sequencing; everything advances only on an accepted frame tick.
  always_comb begin
    state_next = state;
    scene_next = scene;
    fade_next  = fade;
    fc_next    = frame_count;
    start_next = 1'b0;
    if (step) begin
      case (state)
        ST_FADE_IN: begin
          if (skip_eff) begin
            state_next = ST_FADE_OUT;
            fc_next    = 8'd0;
          end else if (frame_count == STEP_LAST) begin
            fade_next = fade + 2'd1;
            fc_next   = 8'd0;
            if (fade == 2'd2) state_next = ST_HOLD;
          end else begin
            fc_next = frame_count + 8'd1;
          end
        end
        ST_HOLD: begin
          if (skip_eff || frame_count == HOLD_LAST) begin
            state_next = ST_FADE_OUT;
            fc_next    = 8'd0;
          end else begin
            fc_next = frame_count + 8'd1;
          end
        end
        ST_FADE_OUT: begin
          if (frame_count == STEP_LAST) begin
            fade_next = fade - 2'd1;
            fc_next   = 8'd0;
            if (fade == 2'd1) begin
              state_next = ST_FADE_IN;
              scene_next = scene_inc;
              start_next = 1'b1;
            end
          end else begin
            fc_next = frame_count + 8'd1;
          end
        end
        default: begin
          state_next = ST_FADE_IN;
          fade_next  = 2'd0;
          fc_next    = 8'd0;
        end
      endcase
    end
  end

  // Output and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FADE_IN;
      scene       <= '0;
      fade        <= 2'd0;
      frame_count <= 8'd0;
      scene_start <= 1'b0;
    end else begin
      state       <= state_next;
      scene       <= scene_next;
      fade        <= fade_next;
      frame_count <= fc_next;
      scene_start <= start_next;
    end
  end
`else
  // Full brightness always; each scene is a single hold phase.
  assign fade = 2'd3;

  // Hold counting; the last hold frame or a skip advances the scene directly.
  always_comb begin
    scene_next = scene;
    fc_next    = frame_count;
    start_next = 1'b0;
    if (step) begin
      if (skip_eff || frame_count == HOLD_LAST) begin
        scene_next = scene_inc;
        fc_next    = 8'd0;
        start_next = 1'b1;
      end else begin
        fc_next = frame_count + 8'd1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene       <= '0;
      frame_count <= 8'd0;
      scene_start <= 1'b0;
    end else begin
      scene       <= scene_next;
      frame_count <= fc_next;
      scene_start <= start_next;
    end
  end
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed bench for scene_sequencer with NUM_SCENES=3,
// HOLD_FRAMES=4, FADE_STEP=2. A second instance uses VSYNC_POL=1 with an
// inverted v_sync and must follow the same timing. Scenario set follows the
// build: SCENE_SEQ_FADE_EN selects the fade scenarios.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst, v_sync, pause, skip;
  logic       v_sync_n;
  logic [1:0] scene, fade, scene_p, fade_p;
  logic [7:0] frame_count, fc_p;
  logic       scene_start, start_p;
  logic       ss_tick, ss_next;
  int         checks = 0;
  int         errors = 0;

`ifdef SCENE_SEQ_FADE_EN
  localparam logic [1:0] FADE_RST = 2'd0;
  int fade_tab[16] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};
  int fc_tab[16]   = '{1, 0, 1, 0, 1, 0, 1, 2, 3, 0, 1, 0, 1, 0, 1, 0};
`else
  localparam logic [1:0] FADE_RST = 2'd3;
`endif

  assign v_sync_n = ~v_sync;

  always #5 clk = ~clk;

  scene_sequencer #(.NUM_SCENES(3), .HOLD_FRAMES(4), .FADE_STEP(2), .VSYNC_POL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .pause(pause), .skip(skip),
    .scene(scene), .fade(fade), .frame_count(frame_count), .scene_start(scene_start));

  scene_sequencer #(.NUM_SCENES(3), .HOLD_FRAMES(4), .FADE_STEP(2), .VSYNC_POL(1'b1)) u_dut_pol (
    .clk(clk), .rst(rst), .v_sync(v_sync_n), .pause(pause), .skip(skip),
    .scene(scene_p), .fade(fade_p), .frame_count(fc_p), .scene_start(start_p));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v_sync = 1'b1; pause = 1'b0; skip = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One frame: v_sync low for two cycles, optional skip aligned with the tick.
  task automatic run_frame(input bit sk);
    @(negedge clk);
    v_sync = 1'b0; skip = sk;
    @(posedge clk); #1;
    ss_tick = scene_start; skip = 1'b0;
    @(posedge clk); #1;
    ss_next = scene_start;
    @(negedge clk);
    v_sync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_skip();
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0;
  endtask

  task automatic test_reset();
    // Asynchronous reset at time zero, before any clock edge.
    rst = 1'b1; v_sync = 1'b1; pause = 1'b0; skip = 1'b0;
    #1;
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL reset_scene got %0d want 0", scene); end
    checks++; if (fade !== FADE_RST) begin errors++; $display("FAIL reset_fade got %0d want %0d", fade, FADE_RST); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    checks++; if (scene_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0d want 0", scene_start); end
    // Release with v_sync already active: no tick may occur.
    @(negedge clk); v_sync = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL release_notick got fc %0d want 0", frame_count); end
    checks++; if (fc_p !== 8'd0) begin errors++; $display("FAIL release_notick_pol got fc %0d want 0", fc_p); end
    @(negedge clk); v_sync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

`ifdef SCENE_SEQ_FADE_EN
  task automatic test_full_cycle();
    int k;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      run_frame(1'b0);
      k = (i - 1) % 16;
      checks++; if (fade !== 2'(fade_tab[k]) || frame_count !== 8'(fc_tab[k]) || scene !== 2'((i / 16) % 3))
        begin errors++; $display("FAIL cycle_t%0d got f%0d fc%0d s%0d want f%0d fc%0d s%0d", i, fade, frame_count, scene, fade_tab[k], fc_tab[k], (i / 16) % 3); end
      checks++; if (fade_p !== 2'(fade_tab[k]) || fc_p !== 8'(fc_tab[k]) || scene_p !== 2'((i / 16) % 3))
        begin errors++; $display("FAIL pol_t%0d got f%0d fc%0d s%0d want f%0d fc%0d s%0d", i, fade_p, fc_p, scene_p, fade_tab[k], fc_tab[k], (i / 16) % 3); end
      checks++; if (ss_tick !== (k == 15) || ss_next !== 1'b0)
        begin errors++; $display("FAIL start_t%0d got %0d/%0d want %0d/0", i, ss_tick, ss_next, k == 15); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    repeat (2) run_frame(1'b0);
    pause = 1'b1;
    repeat (5) run_frame(1'b0);
    checks++; if (fade !== 2'd1 || frame_count !== 8'd0 || scene !== 2'd0)
      begin errors++; $display("FAIL pause_frozen got f%0d fc%0d s%0d want f1 fc0 s0", fade, frame_count, scene); end
    pause = 1'b0;
    repeat (3) run_frame(1'b0);
    checks++; if (fade !== 2'd2 || frame_count !== 8'd1)
      begin errors++; $display("FAIL pause_resume got f%0d fc%0d want f2 fc1", fade, frame_count); end
    run_frame(1'b0);
    checks++; if (fade !== 2'd3 || frame_count !== 8'd0)
      begin errors++; $display("FAIL pause_full got f%0d fc%0d want f3 fc0", fade, frame_count); end
  endtask

  task automatic test_skip();
    // Skip between ticks 7 and 8.
    do_reset();
    repeat (7) run_frame(1'b0);
    pulse_skip();
    run_frame(1'b0);
    checks++; if (fade !== 2'd3 || frame_count !== 8'd0)
      begin errors++; $display("FAIL skip_enter got f%0d fc%0d want f3 fc0", fade, frame_count); end
    repeat (5) run_frame(1'b0);
    checks++; if (fade !== 2'd1 || frame_count !== 8'd1 || scene !== 2'd0)
      begin errors++; $display("FAIL skip_mid got f%0d fc%0d s%0d want f1 fc1 s0", fade, frame_count, scene); end
    run_frame(1'b0);
    checks++; if (scene !== 2'd1 || fade !== 2'd0 || ss_tick !== 1'b1)
      begin errors++; $display("FAIL skip_adv got s%0d f%0d st%0d want s1 f0 st1", scene, fade, ss_tick); end
    // Skip in the same cycle as tick 8.
    do_reset();
    repeat (7) run_frame(1'b0);
    run_frame(1'b1);
    checks++; if (fade !== 2'd3 || frame_count !== 8'd0)
      begin errors++; $display("FAIL skipsame_enter got f%0d fc%0d want f3 fc0", fade, frame_count); end
    repeat (6) run_frame(1'b0);
    checks++; if (scene !== 2'd1 || ss_tick !== 1'b1)
      begin errors++; $display("FAIL skipsame_adv got s%0d st%0d want s1 st1", scene, ss_tick); end
    // Skip during fade-out leaves timing unchanged.
    do_reset();
    repeat (10) run_frame(1'b0);
    pulse_skip();
    repeat (5) run_frame(1'b0);
    checks++; if (scene !== 2'd0 || fade !== 2'd1)
      begin errors++; $display("FAIL skipout_t15 got s%0d f%0d want s0 f1", scene, fade); end
    run_frame(1'b0);
    checks++; if (scene !== 2'd1 || fade !== 2'd0)
      begin errors++; $display("FAIL skipout_t16 got s%0d f%0d want s1 f0", scene, fade); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (12) run_frame(1'b0);
    pulse_skip();
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (scene !== 2'd0 || fade !== 2'd0 || frame_count !== 8'd0 || scene_start !== 1'b0)
      begin errors++; $display("FAIL midrst got s%0d f%0d fc%0d st%0d want all 0", scene, fade, frame_count, scene_start); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(1'b0);
    checks++; if (fade !== 2'd0 || frame_count !== 8'd1 || scene !== 2'd0)
      begin errors++; $display("FAIL midrst_after got f%0d fc%0d s%0d want f0 fc1 s0", fade, frame_count, scene); end
  endtask
`else
  task automatic test_hold_cycle();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      run_frame(1'b0);
      checks++; if (fade !== 2'd3 || frame_count !== 8'(i % 4) || scene !== 2'((i / 4) % 3))
        begin errors++; $display("FAIL hold_t%0d got f%0d fc%0d s%0d want f3 fc%0d s%0d", i, fade, frame_count, scene, i % 4, (i / 4) % 3); end
      checks++; if (fade_p !== 2'd3 || fc_p !== 8'(i % 4) || scene_p !== 2'((i / 4) % 3))
        begin errors++; $display("FAIL pol_t%0d got f%0d fc%0d s%0d want f3 fc%0d s%0d", i, fade_p, fc_p, scene_p, i % 4, (i / 4) % 3); end
      checks++; if (ss_tick !== (i % 4 == 0) || ss_next !== 1'b0)
        begin errors++; $display("FAIL start_t%0d got %0d/%0d want %0d/0", i, ss_tick, ss_next, i % 4 == 0); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    run_frame(1'b0);
    pause = 1'b1;
    run_frame(1'b1);
    run_frame(1'b0);
    checks++; if (frame_count !== 8'd1 || scene !== 2'd0 || ss_tick !== 1'b0)
      begin errors++; $display("FAIL pause_frozen got fc%0d s%0d st%0d want fc1 s0 st0", frame_count, scene, ss_tick); end
    pause = 1'b0;
    run_frame(1'b0);
    checks++; if (scene !== 2'd1 || frame_count !== 8'd0 || ss_tick !== 1'b1)
      begin errors++; $display("FAIL pause_kept_skip got s%0d fc%0d st%0d want s1 fc0 st1", scene, frame_count, ss_tick); end
    run_frame(1'b0);
    checks++; if (scene !== 2'd1 || frame_count !== 8'd1)
      begin errors++; $display("FAIL pause_cleared got s%0d fc%0d want s1 fc1", scene, frame_count); end
  endtask

  task automatic test_skip();
    do_reset();
    repeat (2) run_frame(1'b0);
    pulse_skip();
    run_frame(1'b0);
    checks++; if (scene !== 2'd1 || frame_count !== 8'd0 || ss_tick !== 1'b1)
      begin errors++; $display("FAIL skip_idle got s%0d fc%0d st%0d want s1 fc0 st1", scene, frame_count, ss_tick); end
    run_frame(1'b1);
    checks++; if (scene !== 2'd2 || frame_count !== 8'd0 || ss_tick !== 1'b1)
      begin errors++; $display("FAIL skip_same got s%0d fc%0d st%0d want s2 fc0 st1", scene, frame_count, ss_tick); end
    run_frame(1'b0);
    checks++; if (scene !== 2'd2 || frame_count !== 8'd1 || ss_tick !== 1'b0)
      begin errors++; $display("FAIL skip_after got s%0d fc%0d st%0d want s2 fc1 st0", scene, frame_count, ss_tick); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) run_frame(1'b0);
    pulse_skip();
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (scene !== 2'd0 || fade !== 2'd3 || frame_count !== 8'd0 || scene_start !== 1'b0)
      begin errors++; $display("FAIL midrst got s%0d f%0d fc%0d st%0d want s0 f3 fc0 st0", scene, fade, frame_count, scene_start); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(1'b0);
    checks++; if (scene !== 2'd0 || frame_count !== 8'd1)
      begin errors++; $display("FAIL midrst_after got s%0d fc%0d want s0 fc1", scene, frame_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SCENE_SEQ_FADE_EN
    test_full_cycle();
`else
    test_hold_cycle();
`endif
    test_pause();
    test_skip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
